// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central stall/flush sequencer for the 5-stage RISC-V pipeline. Produces the
// load enables and flush (NOP/bubble) controls for the PC, IF/ID, ID/EX,
// EX/MEM and MEM/WB registers. It resolves three conditions, highest priority
// first: multi-cycle data-memory accesses, taken-branch redirects and
// load-use hazards. It also keeps a saturating count of stalled cycles.
//
// Optional feature (compile-time macro PIPE_CTRL_TIMEOUT_EN):
//   When defined, a memory access that stays in WAIT for TIMEOUT_CYCLES
//   cycles is force-released as if acknowledged, and timeout_err_o is set
//   until reset. When undefined, WAIT is unbounded and timeout_err_o is 0.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   id_rs1_i, id_rs2_i    source registers of the instruction in ID
//   id_uses_rs1_i/rs2_i   ID instruction actually reads rs1 / rs2
//   ex_rd_i               destination register of the instruction in EX
//   ex_mem_read_i         EX instruction is a load
//   ex_branch_taken_i     EX resolved a taken branch/jump
//   mem_op_i              MEM instruction is a load/store
//   dmem_ack_i            data memory completes the current access
//   dmem_req_o            data memory request (follows mem_op_i)
//   *_en_o / *_flush_o    pipeline register enables and flushes
//   stall_cnt_o           cycles with pc_en_o low, saturating
//   timeout_err_o         sticky memory-timeout flag
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int STALL_CNT_W    = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4:0]             id_rs1_i,
    input  logic [4:0]             id_rs2_i,
    input  logic                   id_uses_rs1_i,
    input  logic                   id_uses_rs2_i,
    input  logic [4:0]             ex_rd_i,
    input  logic                   ex_mem_read_i,
    input  logic                   ex_branch_taken_i,
    input  logic                   mem_op_i,
    input  logic                   dmem_ack_i,
    output logic                   dmem_req_o,
    output logic                   pc_en_o,
    output logic                   ifid_en_o,
    output logic                   ifid_flush_o,
    output logic                   idex_en_o,
    output logic                   idex_flush_o,
    output logic                   exmem_en_o,
    output logic                   memwb_en_o,
    output logic                   memwb_flush_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o,
    output logic                   timeout_err_o
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic timeout_hit;
    logic timeout_err_q;
    logic eff_ack;
    logic mem_stall;
    logic load_use;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("pipe_hazard_ctrl: TIMEOUT_CYCLES must be at least 1");
    end

    // A forced timeout release behaves exactly like a real acknowledge.
    assign eff_ack   = dmem_ack_i | timeout_hit;
    assign mem_stall = mem_op_i & ~eff_ack;

    // x0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign load_use = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                      ((id_uses_rs1_i && (id_rs1_i == ex_rd_i)) ||
                       (id_uses_rs2_i && (id_rs2_i == ex_rd_i)));

    // ---------------- FSM ----------------
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (mem_stall) state_d = ST_WAIT;
            ST_WAIT: if (eff_ack)   state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    // ---------------- Optional memory timeout ----------------
`ifdef PIPE_CTRL_TIMEOUT_EN
    localparam int WAIT_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WAIT_CNT_W-1:0] wait_cnt_q;

    // wait_cnt_q holds the number of WAIT cycles already completed, so the
    // TIMEOUT_CYCLES-th WAIT cycle is the one that releases.
    assign timeout_hit = (state_q == ST_WAIT) &&
                         (wait_cnt_q == WAIT_CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            if (state_q == ST_WAIT && state_d == ST_WAIT) wait_cnt_q <= wait_cnt_q + 1'b1;
            else                                          wait_cnt_q <= '0;
            if (timeout_hit) timeout_err_q <= 1'b1;
        end
    end
`else
    assign timeout_hit   = 1'b0;
    assign timeout_err_q = 1'b0;
`endif

    // ---------------- Control outputs ----------------
    logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic exmem_en, memwb_en, memwb_flush;

    // NOTE: every output gets a default before the priority chain, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_flush  = 1'b0;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        memwb_flush = 1'b0;
        if (mem_stall) begin
            // Freeze everything upstream of MEM; branch/load-use inputs hold
            // while frozen and are acted on once the access completes.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (ex_branch_taken_i) begin
            // Squashing ID also discards any load-use hazard it carried.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    // ---------------- Stall-cycle counter ----------------
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            stall_cnt_q <= '0;
        else if (!pc_en && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
    end

    // All outputs are forced low while reset is asserted.
    assign dmem_req_o    = rst_n & mem_op_i;
    assign pc_en_o       = rst_n & pc_en;
    assign ifid_en_o     = rst_n & ifid_en;
    assign ifid_flush_o  = rst_n & ifid_flush;
    assign idex_en_o     = rst_n & idex_en;
    assign idex_flush_o  = rst_n & idex_flush;
    assign exmem_en_o    = rst_n & exmem_en;
    assign memwb_en_o    = rst_n & memwb_en;
    assign memwb_flush_o = rst_n & memwb_flush;
    assign stall_cnt_o   = rst_n ? stall_cnt_q : '0;
    assign timeout_err_o = rst_n & timeout_err_q;

endmodule
